fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; it is word aligned.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL request an instruction-memory read.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned read address.
REQ-006 imem_ack  input  1  SHALL mark imem_rdata valid; it may assert in the same cycle as imem_req.
REQ-007 imem_rdata  input  32  SHALL carry the instruction word.
REQ-008 ins  output  32  SHALL carry the instruction presented to the control decoder.
REQ-009 ins_valid  output  1  SHALL mark ins and ins_pc valid.
REQ-010 ins_ready  input  1  SHALL mean the downstream consumer accepts ins this cycle.
REQ-011 ins_pc  output  32  SHALL carry the address of ins.
REQ-012 jump  input  1  SHALL request a redirect to jump_target (jr/jal).
REQ-013 jump_target  input  32  SHALL carry the jump destination.
REQ-014 branch_taken  input  1  SHALL request a redirect to branch_target (bleu taken).
REQ-015 branch_target  input  32  SHALL carry the branch destination.
REQ-016 misalign  output  1  SHALL pulse for one cycle when an accepted redirect target has bits [1:0] != 0.
REQ-017 fetch_count  output  32  SHALL count instructions handed off (ins_valid & ins_ready).

Function
REQ-018 The FSM SHALL have exactly the states REQ (imem_req=1, awaiting imem_ack) and HOLD (ins_valid=1, awaiting ins_ready).
REQ-019 In REQ, imem_addr SHALL equal the PC register and SHALL stay stable until imem_ack.
REQ-020 In REQ with imem_ack=1 and no kill pending, the block SHALL register imem_rdata into ins and the PC into ins_pc, and SHALL enter HOLD next cycle.
REQ-021 In HOLD with ins_ready=1, the block SHALL set PC <= ins_pc + 4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0), increment fetch_count (wrapping), and enter REQ next cycle.
REQ-022 In HOLD with ins_ready=0, ins and ins_pc SHALL hold their values.
REQ-023 Best-case throughput SHALL be one instruction per 2 cycles; ack-to-ins_valid latency SHALL be 1 cycle.
REQ-024 The redirect target SHALL be jump_target when jump=1 (jump wins if both are asserted), otherwise branch_target when branch_taken=1; the target SHALL be forced to {target[31:2],2'b00}.
REQ-025 A redirect in HOLD SHALL set PC to the target, deassert ins_valid next cycle, and enter REQ; if ins_ready=1 in the same cycle, the handoff SHALL still count, but PC SHALL take the target, not ins_pc+4.
REQ-026 A redirect in REQ with imem_ack=1 SHALL discard imem_rdata, load the target into PC, and stay in REQ.
REQ-027 A redirect in REQ with imem_ack=0 SHALL set a kill flag and latch the target; the pending ack SHALL be discarded and then clear kill, and the next REQ SHALL use the latched target.
REQ-028 A later redirect while kill is pending SHALL overwrite the latched target.
REQ-029 While kill is pending, imem_addr SHALL hold the original address until that ack.
REQ-030 misalign SHALL pulse only for redirects actually applied under REQ-025..028.

Reset
REQ-031 While reset_n=0: state=REQ, PC=RESET_PC, ins=0, ins_pc=0, ins_valid=0, kill=0, misalign=0, and fetch_count=0, all asynchronously.
REQ-032 Outputs after reset: imem_req=1 and imem_addr=RESET_PC.
REQ-033 Assertion of reset mid-transaction SHALL abandon any outstanding read; an ack arriving during reset SHALL be ignored.
REQ-034 After reset_n deasserts, the first rising edge SHALL be able to accept an ack for RESET_PC.

Verification
REQ-035 Reset release, imem_ack tied to 1, ins_ready=1, rdata=addr -> ins_valid every other cycle with ins_pc=0,4,8; fetch_count=3 after the third handoff.
REQ-036 ins_ready=0 for 5 cycles in HOLD -> ins and ins_pc constant, imem_req=0, fetch_count unchanged.
REQ-037 jump=1 with jump_target=32'h100 and branch_taken=1 with branch_target=32'h200, both in HOLD -> the next imem_addr is 32'h100 and ins_valid drops.
REQ-038 branch_taken with target 32'h40 while in REQ with ack delayed 3 cycles -> the delayed rdata is never presented, the next request is to 32'h40, and the first ins_pc is 32'h40.
REQ-039 jump_target=32'h103 -> misalign pulses for 1 cycle and imem_addr=32'h100.
REQ-040 reset_n pulsed low while in HOLD with ins_valid=1 -> ins_valid=0 immediately, and the restart fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch front end. It issues one instruction-memory read at a
//   time, then holds the returned word for the control decoder until that
//   decoder takes it. Jump and taken-branch redirects can arrive at any time.
//   A read that is already in flight when a redirect arrives is discarded
//   when its acknowledge returns.
//
// Ports
//   clk            : system clock, rising edge
//   reset_n        : asynchronous active-low reset
//   imem_req       : instruction-memory read request
//   imem_addr      : word-aligned read address (the PC register)
//   imem_ack       : imem_rdata valid (may coincide with imem_req)
//   imem_rdata     : instruction word from memory
//   ins            : instruction presented downstream
//   ins_valid      : ins / ins_pc valid
//   ins_ready      : downstream accepts ins this cycle
//   ins_pc         : address of ins
//   jump           : redirect request to jump_target (has priority)
//   jump_target    : jump destination
//   branch_taken   : redirect request to branch_target
//   branch_target  : branch destination
//   misalign       : one-cycle pulse, applied redirect target had bits[1:0]!=0
//   fetch_count    : number of handoffs (ins_valid & ins_ready), wrapping
//
// State | meaning
// ------+-----------------------------------------------
// REQ   | imem_req=1, waiting for imem_ack at PC
// HOLD  | ins_valid=1, waiting for ins_ready

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] ins_pc_q, ins_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_tgt_q, kill_tgt_d;
  logic [31:0] count_q, count_d;
  logic        misalign_q, misalign_d;

  logic        redir;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;

  assign redir   = jump | branch_taken;
  assign tgt_raw = jump ? jump_target : branch_target;
  assign tgt     = {tgt_raw[31:2], 2'b00};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      ins_q      <= '0;
      ins_pc_q   <= '0;
      kill_q     <= 1'b0;
      kill_tgt_q <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      ins_pc_q   <= ins_pc_d;
      kill_q     <= kill_d;
      kill_tgt_q <= kill_tgt_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    ins_pc_d   = ins_pc_q;
    kill_d     = kill_q;
    kill_tgt_d = kill_tgt_q;
    count_d    = count_q;
    misalign_d = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        if (imem_ack) begin
          if (redir) begin
            // Fresh redirect beats both the returning data and any
            // previously latched kill target.
            pc_d       = tgt;
            kill_d     = 1'b0;
            misalign_d = |tgt_raw[1:0];
          end else if (kill_q) begin
            pc_d   = kill_tgt_q;
            kill_d = 1'b0;
          end else begin
            ins_d    = imem_rdata;
            ins_pc_d = pc_q;
            state_d  = ST_HOLD;
          end
        end else if (redir) begin
          // Read in flight: keep the address stable, remember where to go.
          kill_d     = 1'b1;
          kill_tgt_d = tgt;
          misalign_d = |tgt_raw[1:0];
        end
      end

      ST_HOLD: begin
        if (ins_ready) begin
          count_d = count_q + 32'd1;
        end
        if (redir) begin
          pc_d       = tgt;
          state_d    = ST_REQ;
          misalign_d = |tgt_raw[1:0];
        end else if (ins_ready) begin
          pc_d    = ins_pc_q + 32'd4;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_REQ;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req    = (state_q == ST_REQ);
    imem_addr   = pc_q;
    ins_valid   = (state_q == ST_HOLD);
    ins         = ins_q;
    ins_pc      = ins_pc_q;
    misalign    = misalign_q;
    fetch_count = count_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_pc;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        misalign;
  logic [31:0] fetch_count;

  logic        echo;
  logic [31:0] rdata_val;
  int          n_cmp;
  int          n_fail;

  assign imem_rdata = echo ? imem_addr : rdata_val;

  fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ins           (ins),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .ins_pc        (ins_pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .misalign      (misalign),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; imem_ack = 1'b1; ins_ready = 1'b1; echo = 1'b1; rdata_val = '0;
    jump = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_target = '0;

    // Reset, ack held high must be ignored
    nstep(); nstep();
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", ins_valid, 0);
    chk("rst_ins", ins, 0);
    chk("rst_ins_pc", ins_pc, 0);
    chk("rst_cnt", fetch_count, 0);
    chk("rst_mis", misalign, 0);
    reset_n = 1'b1;

    // Streaming with ack tied high, rdata = addr
    for (int i = 0; i < 3; i++) begin
      nstep();
      chk("str_valid", ins_valid, 1);
      chk("str_pc", ins_pc, 32'(i * 4));
      chk("str_ins", ins, 32'(i * 4));
      chk("str_req_lo", imem_req, 0);
      nstep();
      chk("str_gap", ins_valid, 0);
      chk("str_addr", imem_addr, 32'(i * 4 + 4));
      chk("str_cnt", fetch_count, 32'(i + 1));
    end

    // Stall in HOLD for 5 cycles
    nstep();
    chk("st_valid", ins_valid, 1);
    chk("st_pc0", ins_pc, 32'hC);
    ins_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nstep();
      chk("st_ins", ins, 32'hC);
      chk("st_pc", ins_pc, 32'hC);
      chk("st_req", imem_req, 0);
      chk("st_cnt", fetch_count, 3);
    end

    // Jump and branch together in HOLD: jump wins
    jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
    imem_ack = 1'b0;
    nstep();
    jump = 1'b0; branch_taken = 1'b0;
    chk("jb_addr", imem_addr, 32'h100);
    chk("jb_valid", ins_valid, 0);
    chk("jb_req", imem_req, 1);
    chk("jb_mis", misalign, 0);
    chk("jb_cnt", fetch_count, 3);

    // Branch while a read is outstanding, ack 3 cycles later
    branch_taken = 1'b1; branch_target = 32'h40;
    nstep();
    branch_taken = 1'b0;
    chk("kill_addr_hold", imem_addr, 32'h100);
    nstep();
    chk("kill_addr_hold2", imem_addr, 32'h100);
    chk("kill_valid", ins_valid, 0);
    nstep();
    echo = 1'b0; rdata_val = 32'hDEAD_BEEF; imem_ack = 1'b1;
    nstep();
    chk("kill_discard", ins_valid, 0);
    chk("kill_new_addr", imem_addr, 32'h40);
    chk("kill_req", imem_req, 1);
    rdata_val = 32'hAAAA_0040;
    nstep();
    chk("kill_valid2", ins_valid, 1);
    chk("kill_pc", ins_pc, 32'h40);
    chk("kill_ins", ins, 32'hAAAA_0040);

    // Misaligned jump in HOLD with ready: handoff counts, PC takes target
    jump = 1'b1; jump_target = 32'h103; ins_ready = 1'b1;
    nstep();
    jump = 1'b0; rdata_val = 32'h1111_0100;
    chk("mis_pulse", misalign, 1);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_cnt", fetch_count, 4);
    chk("mis_valid", ins_valid, 0);
    nstep();
    chk("mis_gone", misalign, 0);
    chk("mis_valid2", ins_valid, 1);
    chk("mis_pc", ins_pc, 32'h100);
    chk("mis_ins", ins, 32'h1111_0100);

    // Reset pulse in HOLD
    ins_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid", ins_valid, 0);
    chk("mr_cnt", fetch_count, 0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_req", imem_req, 1);
    chk("mr_ins", ins, 0);
    nstep();
    chk("mr_ack_ignored", ins_valid, 0);
    reset_n = 1'b1; rdata_val = 32'hCAFE_0000; ins_ready = 1'b1;
    nstep();
    chk("mr_restart_valid", ins_valid, 1);
    chk("mr_restart_pc", ins_pc, 32'h0);
    chk("mr_restart_ins", ins, 32'hCAFE_0000);

    // PC wrap from FFFFFFFC to 0
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    nstep();
    jump = 1'b0; rdata_val = 32'h1234_5678;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_cnt1", fetch_count, 1);
    nstep();
    chk("wr_pc", ins_pc, 32'hFFFF_FFFC);
    chk("wr_ins", ins, 32'h1234_5678);
    nstep();
    chk("wr_addr0", imem_addr, 32'h0);
    chk("wr_cnt2", fetch_count, 2);

    // Second redirect while kill pending overwrites the latched target
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
    nstep();
    branch_taken = 1'b0; jump = 1'b1; jump_target = 32'hC0;
    nstep();
    jump = 1'b0;
    chk("ow_addr_hold", imem_addr, 32'h0);
    imem_ack = 1'b1;
    nstep();
    chk("ow_addr", imem_addr, 32'hC0);
    chk("ow_valid", ins_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
